// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM status, machine word, and the RAM arbiter's
// FSM state and grant encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } arbstate_t;

    typedef enum logic {
        INSTR,
        DATA
    } grant_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant chooser for the RAM arbiter.
// Ports: iREQ/dREQ request flags, last_grant (RAM_ARB_RR_EN only),
// grant = port to serve next (only meaningful when a request exists).
// RAM_ARB_RR_EN: alternate on contention; otherwise data has priority.
module ram_arb_pick
    import cpu_types_pkg::*;
(
    input  logic   iREQ,
    input  logic   dREQ,
`ifdef RAM_ARB_RR_EN
    input  grant_t last_grant,
`endif
    output grant_t grant
);

`ifdef RAM_ARB_RR_EN
    always_comb begin
        if (iREQ && dREQ)
            grant = (last_grant == DATA) ? INSTR : DATA;
        else
            grant = dREQ ? DATA : INSTR;
    end
`else
    // With no request at all the result is ignored by the caller.
    always_comb begin
        grant = (dREQ || !iREQ) ? DATA : INSTR;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port variable-latency RAM between instruction fetch
// and data ports. Ports: CLK, nRST (async active-low); i*/d* pipeline
// requests with wait/load returns; ram* drive the RAM, ramload/ramstate
// come back. Optional macro RAM_ARB_RR_EN enables round-robin arbitration.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int            AW  = 32,
    parameter logic [AW-1:0] BAD = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [AW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic          dwait,
    output logic [AW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  ramstate_t     ramstate
);

    arbstate_t state, next_state;
    grant_t    pick;
    logic      dreq;

    assign dreq = dREN | dWEN;

`ifdef RAM_ARB_RR_EN
    grant_t last_grant;

    // A completion is visible as the granted port's wait going low.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last_grant <= DATA;
        else if (!iwait)
            last_grant <= INSTR;
        else if (!dwait)
            last_grant <= DATA;
    end
`endif

    ram_arb_pick u_pick (
        .iREQ       (iREN),
        .dREQ       (dreq),
`ifdef RAM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (pick)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = BAD;
        dload      = BAD;
        unique case (state)
            IDLE: begin
                // Arbitrate only; the RAM is driven from the next cycle.
                if (dreq || iREN)
                    next_state = (pick == DATA) ? DGRANT : IGRANT;
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                // Write wins if both enables are raised.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait      = 1'b0;
                    dload      = dWEN ? BAD : ramload;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
